// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared state encoding and default widths for the debug capture buffer
package debug_pkg;

  localparam int FRAME_W_DEF = 9;
  localparam int DATA_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } dbg_state_e;

endpackage

// File: rtl/debug_hist_ram.sv
// rtl/debug_hist_ram.sv - DEPTH x FRAME_W history store, one write port, registered read port
module debug_hist_ram #(
  parameter int FRAME_W = 9,
  parameter int DEPTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [FRAME_W-1:0]       wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [FRAME_W-1:0]       rdata
);

  logic [FRAME_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read register holds the last popped entry until the next pop or a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
  end

endmodule

// File: rtl/debug_capture_buffer.sv
// rtl/debug_capture_buffer.sv - debug snoop of frames/register with DEPTH-deep history FIFO
// Optional trigger-armed capture when DEBUG_CAPTURE_TRIGGER_EN is defined.
module debug_capture_buffer
  import debug_pkg::*;
#(
  parameter int  FRAME_W = FRAME_W_DEF,
  parameter int  DATA_W  = DATA_W_DEF,
  parameter int  DEPTH   = 8,
  parameter int  WRAP    = 0,
  parameter int  CNT_W   = 16,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               debug_en,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame,
  input  logic [DATA_W-1:0]  data_in,
`ifdef DEBUG_CAPTURE_TRIGGER_EN
  input  logic [FRAME_W-1:0] trig_value,
  input  logic [FRAME_W-1:0] trig_mask,
`endif
  input  logic               clear,
  input  logic               rd_en,
  output logic [FRAME_W-1:0] dbg_frame,
  output logic [DATA_W-1:0]  dbg_reg,
  output logic [FRAME_W-1:0] rd_data,
  output logic               rd_valid,
  output logic [LVL_W-1:0]   level,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic [CNT_W-1:0]   frame_cnt
);

  dbg_state_e       state, state_nxt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             live, hit, accept, do_rd, do_wr, drop;

`ifdef DEBUG_CAPTURE_TRIGGER_EN
  localparam dbg_state_e ST_START = ARMED;
  assign hit = ((frame ^ trig_value) & trig_mask) == '0;
`else
  localparam dbg_state_e ST_START = CAPTURE;
  assign hit = 1'b1;
`endif

  assign empty  = (level == '0);
  assign full   = (level == LVL_W'(DEPTH));
  assign live   = debug_en && (state != IDLE);
  assign accept = live && frame_valid && !clear && ((state == CAPTURE) || hit);
  assign do_rd  = live && !clear && rd_en && !empty;
  // A pop in the same cycle frees a slot, so a full buffer only drops/overwrites without one.
  assign do_wr  = accept && (!full || do_rd || (WRAP != 0));
  assign drop   = accept && full && !do_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ST_START;
      ARMED:   if (accept) state_nxt = CAPTURE;
      CAPTURE: if (clear)  state_nxt = ST_START;
      default: state_nxt = IDLE;
    endcase
    if (!debug_en) state_nxt = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || !live) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
      dbg_frame <= '0;
      dbg_reg   <= '0;
      rd_valid  <= 1'b0;
    end else begin
      dbg_reg  <= data_in;
      rd_valid <= do_rd;
      if (clear) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        overflow  <= 1'b0;
        frame_cnt <= '0;
      end else begin
        if (accept) begin
          dbg_frame <= frame;
          if (frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
        end
        if (do_wr) wr_ptr <= wr_ptr + 1'b1;
        // Overwriting the oldest entry drags the read pointer along with it.
        if (do_rd || (do_wr && full)) rd_ptr <= rd_ptr + 1'b1;
        if (drop) overflow <= 1'b1;
        if (do_wr && !do_rd && !full) level <= level + 1'b1;
        else if (do_rd && !do_wr)     level <= level - 1'b1;
      end
    end
  end

  debug_hist_ram #(
    .FRAME_W(FRAME_W),
    .DEPTH  (DEPTH)
  ) u_hist_ram (
    .clk  (clk),
    .rst  (rst),
    .clr  (!live),
    .we   (do_wr),
    .waddr(wr_ptr),
    .wdata(frame),
    .re   (do_rd),
    .raddr(rd_ptr),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_debug_capture_buffer.sv
// tb/tb_debug_capture_buffer.sv - scoreboard bench for debug_capture_buffer, WRAP=0 and WRAP=1 side by side
module tb_debug_capture_buffer;

  localparam int FW    = 9;
  localparam int DW    = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 16;
  localparam int LW    = 4;
`ifdef DEBUG_CAPTURE_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          debug_en = 1'b0, frame_valid = 1'b0, clear = 1'b0, rd_en = 1'b0;
  logic [FW-1:0] frame = '0;
  logic [DW-1:0] data_in = '0;
`ifdef DEBUG_CAPTURE_TRIGGER_EN
  logic [FW-1:0] trig_value = '0, trig_mask = '0;
`endif

  logic [FW-1:0] dbg_frame [2];
  logic [FW-1:0] rd_data   [2];
  logic [DW-1:0] dbg_reg   [2];
  logic          rd_valid  [2];
  logic          empty     [2];
  logic          full      [2];
  logic          overflow  [2];
  logic [LW-1:0] level     [2];
  logic [CW-1:0] frame_cnt [2];

  always #5 clk = ~clk;

  debug_capture_buffer #(.FRAME_W(FW), .DATA_W(DW), .DEPTH(DEPTH), .WRAP(0), .CNT_W(CW)) u_dut0 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .frame_valid(frame_valid), .frame(frame),
    .data_in(data_in),
`ifdef DEBUG_CAPTURE_TRIGGER_EN
    .trig_value(trig_value), .trig_mask(trig_mask),
`endif
    .clear(clear), .rd_en(rd_en), .dbg_frame(dbg_frame[0]), .dbg_reg(dbg_reg[0]),
    .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .level(level[0]), .empty(empty[0]),
    .full(full[0]), .overflow(overflow[0]), .frame_cnt(frame_cnt[0])
  );

  debug_capture_buffer #(.FRAME_W(FW), .DATA_W(DW), .DEPTH(DEPTH), .WRAP(1), .CNT_W(CW)) u_dut1 (
    .clk(clk), .rst(rst), .debug_en(debug_en), .frame_valid(frame_valid), .frame(frame),
    .data_in(data_in),
`ifdef DEBUG_CAPTURE_TRIGGER_EN
    .trig_value(trig_value), .trig_mask(trig_mask),
`endif
    .clear(clear), .rd_en(rd_en), .dbg_frame(dbg_frame[1]), .dbg_reg(dbg_reg[1]),
    .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .level(level[1]), .empty(empty[1]),
    .full(full[1]), .overflow(overflow[1]), .frame_cnt(frame_cnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: history as a plain queue, index 0 = stop-when-full, 1 = overwrite-oldest.
  logic [FW-1:0] mq    [2][$];
  logic [FW-1:0] exp_q [2][$];
  int unsigned   m_cnt [2];
  bit            m_ovf [2];
  bit            m_rv  [2];
  logic [FW-1:0] m_rd  [2];
  logic [FW-1:0] m_frame;
  logic [DW-1:0] m_reg;
  bit            m_live;
  bit            m_armed;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic bit trig_hit();
`ifdef DEBUG_CAPTURE_TRIGGER_EN
    return (frame & trig_mask) == (trig_value & trig_mask);
`else
    return 1'b1;
`endif
  endfunction

  // Predicts the state just after the coming rising edge from the inputs now applied.
  task automatic model_update();
    bit acc;
    if (rst || !debug_en || !m_live) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        m_cnt[i] = 0; m_ovf[i] = 1'b0; m_rv[i] = 1'b0; m_rd[i] = '0;
      end
      m_frame = '0; m_reg = '0; m_armed = TRIG;
      m_live = !rst && debug_en;
      return;
    end
    m_reg = data_in;
    for (int i = 0; i < 2; i++) m_rv[i] = 1'b0;
    if (clear) begin
      for (int i = 0; i < 2; i++) begin
        mq[i].delete(); m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end
      if (TRIG) m_armed = 1'b1;
      return;
    end
    acc = frame_valid && (!m_armed || trig_hit());
    if (acc) begin
      m_frame = frame;
      m_armed = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      if (rd_en && mq[i].size() > 0) begin
        m_rd[i] = mq[i].pop_front();
        m_rv[i] = 1'b1;
        exp_q[i].push_back(m_rd[i]);
      end
      if (acc) begin
        if (m_cnt[i] < 32'hFFFF) m_cnt[i]++;
        if (mq[i].size() < DEPTH) mq[i].push_back(frame);
        else begin
          m_ovf[i] = 1'b1;
          if (i == 1) begin
            void'(mq[i].pop_front());
            mq[i].push_back(frame);
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("level",     i, 32'(level[i]),     32'(mq[i].size()));
      chk("empty",     i, 32'(empty[i]),     32'(mq[i].size() == 0));
      chk("full",      i, 32'(full[i]),      32'(mq[i].size() == DEPTH));
      chk("overflow",  i, 32'(overflow[i]),  32'(m_ovf[i]));
      chk("frame_cnt", i, 32'(frame_cnt[i]), m_cnt[i]);
      chk("dbg_frame", i, 32'(dbg_frame[i]), 32'(m_frame));
      chk("dbg_reg",   i, 32'(dbg_reg[i]),   32'(m_reg));
      chk("rd_valid",  i, 32'(rd_valid[i]),  32'(m_rv[i]));
      chk("rd_data",   i, 32'(rd_data[i]),   32'(m_rd[i]));
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest outstanding expected pop.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_valid[i] === 1'b1) begin
        if (exp_q[i].size() == 0) chk("rd_valid_spurious", i, 32'(rd_valid[i]), 32'd0);
        else                      chk("pop_data", i, 32'(rd_data[i]), 32'(exp_q[i].pop_front()));
      end
    end
  end

  // Caller applies inputs at a falling edge; step advances one clock and checks.
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    frame_valid = 1'b0; rd_en = 1'b0; clear = 1'b0;
    repeat (n) step();
  endtask

  task automatic push(input logic [FW-1:0] f);
    frame_valid = 1'b1; frame = f;
    step();
    frame_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset, then idle with frame strobes ignored.
    step(); step();
    rst = 1'b0;
    repeat (3) begin
      push(9'h1A5);
      step();
    end

    // Basic capture and three pops.
    debug_en = 1'b1; data_in = 4'hA;
    idle(2);
    push(9'h011); push(9'h022); push(9'h033);
    idle(1);
    repeat (3) begin pop(); idle(1); end

    // Fill past full, drain, then pop on empty.
    do_clear();
    for (int k = 1; k <= 10; k++) push(FW'(k));
    repeat (9) pop();
    idle(2);

    // Full with concurrent write and pop, then clear racing a write and a pop.
    do_clear();
    for (int k = 1; k <= 8; k++) push(FW'(k + 'h40));
    frame_valid = 1'b1; rd_en = 1'b1; frame = 9'h055;
    step();
    idle(1);
    clear = 1'b1; frame_valid = 1'b1; rd_en = 1'b1; frame = 9'h066;
    step();
    idle(2);

    // debug_en dropped for one cycle mid-stream.
    for (int k = 0; k < 4; k++) push(FW'(9'h0A0 + k));
    debug_en = 1'b0;
    step();
    debug_en = 1'b1;
    idle(2);

`ifdef DEBUG_CAPTURE_TRIGGER_EN
    trig_value = 9'h0F0; trig_mask = 9'h0F0;
    debug_en = 1'b0; step();
    debug_en = 1'b1; idle(2);
    push(9'h001); push(9'h0F3); push(9'h002);
    idle(1);
    repeat (3) pop();
    trig_mask = '0;
`endif

    // Randomized traffic: write-heavy first half, read-heavy second half.
    for (int c = 0; c < 2000; c++) begin
      debug_en    = ($urandom_range(0, 127) != 0);
      clear       = ($urandom_range(0, 99) == 0);
      frame_valid = ($urandom_range(0, 9) < 6);
      rd_en       = ($urandom_range(0, 9) < ((c < 1000) ? 3 : 7));
      frame       = FW'($urandom);
      data_in     = DW'($urandom);
      step();
    end
    debug_en = 1'b1;
    idle(3);

    for (int i = 0; i < 2; i++) chk("pops_outstanding", i, 32'(exp_q[i].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_capture_buffer.md
Name: debug_capture_buffer

Overview:
- Parametrised debug capture block. Snoops received serial frames (frame/frame_valid) and a live register value (data_in) while debug mode is enabled.
- Holds the last frame and last register value for direct display, and stores a DEPTH-deep history of frames for readout over a read handshake.
- Sits between the serial receiver/register file and the debug display/readout path.

Parameters:
- FRAME_W, 9, frame width in bits
- DATA_W, 4, snooped register width
- DEPTH, 8, history entries (power of two, >=2)
- WRAP, 0, 0 = stop capturing when full; 1 = overwrite oldest entry when full
- CNT_W, 16, width of the saturating frame counter

Ports:
- clk  in  1  clock
- rst  in  1  reset
- debug_en  in  1  debug mode enable; low = block held cleared
- frame_valid  in  1  one-cycle strobe, frame is valid
- frame  in  FRAME_W  received frame
- data_in  in  DATA_W  live register value
- clear  in  1  synchronous flush of history, counter and flags
- rd_en  in  1  pop request for the oldest history entry
- dbg_frame  out  FRAME_W  last captured frame
- dbg_reg  out  DATA_W  registered data_in
- rd_data  out  FRAME_W  popped entry
- rd_valid  out  1  rd_data valid (one-cycle pulse)
- level  out  $clog2(DEPTH)+1  number of stored entries
- empty  out  1  level==0
- full  out  1  level==DEPTH
- overflow  out  1  sticky: a frame was dropped or overwritten
- frame_cnt  out  CNT_W  frames seen since clear, saturating

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset all outputs and internal pointers go to 0 and empty=1.
- State machine:
  - IDLE (debug_en=0): every register is cleared each cycle, with the same values as reset.
  - CAPTURE (debug_en=1).
  - IDLE->CAPTURE on debug_en=1. CAPTURE->IDLE on debug_en=0. The transition takes effect on the next clock edge.
- dbg_reg: loads data_in every cycle in CAPTURE (1-cycle latency).
- dbg_frame: loads frame when frame_valid=1 in CAPTURE, otherwise holds. Frame accepted in cycle N appears at N+1.
- Frame acceptance (frame_valid in CAPTURE):
  - frame_cnt increments, saturating at all-ones.
  - Frame is written to history at wr_ptr, and level updates at N+1.
- Write when full:
  - WRAP=0: frame is dropped, overflow is set, and dbg_frame and frame_cnt still update.
  - WRAP=1: oldest entry is overwritten, rd_ptr advances, level stays DEPTH, overflow is set.
- Read handshake:
  - rd_en with !empty: rd_data = entry at rd_ptr, registered, with rd_valid=1 in cycle N+1.
  - rd_en with empty: ignored, rd_valid=0, no error flag.
  - rd_data holds its value between pops.
- Simultaneous read and write:
  - Both proceed and level is unchanged.
  - When full, a concurrent pop frees a slot, so no drop and no overflow in either mode.
  - When empty, the read is ignored and the write proceeds.
- Pointers: $clog2(DEPTH) bits, wrapping naturally at DEPTH.
- clear (CAPTURE only): next cycle level=0, pointers=0, frame_cnt=0, overflow=0.
  - dbg_frame and dbg_reg are not affected.
  - clear wins over a same-cycle write and read: the frame is not stored or counted, and rd_valid=0.
- debug_en falling mid-operation: all history is lost. No pop completes after the cycle in which debug_en is sampled low.

Optional Feature:
- Macro DEBUG_CAPTURE_TRIGGER_EN. Adds inputs trig_value[FRAME_W] and trig_mask[FRAME_W].
- Adds state ARMED: IDLE->ARMED on debug_en, ARMED->CAPTURE on the first frame_valid with (frame & trig_mask)==(trig_value & trig_mask).
- The triggering frame is itself captured. dbg_reg updates in ARMED. Non-matching frames in ARMED are not stored or counted.
- clear in CAPTURE returns the block to ARMED.
- Without the macro: no extra ports, and IDLE->CAPTURE is direct.

Decomposition:
- Shared package debug_pkg: state encoding typedef (IDLE, ARMED, CAPTURE), default widths FRAME_W_DEF=9 and DATA_W_DEF=4.
- One natural sub-module: debug_hist_ram, a DEPTH x FRAME_W single-write, registered-read storage array. All control (pointers, level, flags, FSM) stays in the top level.

Test Plan:
- Reset/idle: rst=1, then debug_en=0 with frame_valid pulses of 9'h1A5 -> all outputs 0, empty=1, frame_cnt=0.
- Basic capture: debug_en=1, data_in=4'hA, frames 9'h011, 9'h022, 9'h033 -> dbg_reg=4'hA one cycle later, dbg_frame=9'h033, level=3, frame_cnt=3. Three pops return 011, 022, 033, each with a one-cycle rd_valid.
- Full, WRAP=0, DEPTH=8: write 10 frames 1..10 -> level=8, overflow=1, frame_cnt=10, pops return 1..8. Then a pop on empty gives rd_valid=0.
- Full, WRAP=1: write frames 1..10 -> overflow=1, pops return 3..10.
- Full with simultaneous write+pop (WRAP=0): pop returns the oldest, the new frame is stored, level stays 8, overflow stays 0. Then clear with concurrent frame_valid -> level=0, frame_cnt=0, overflow=0.
- debug_en drop mid-stream: 4 frames stored, then debug_en=0 for one cycle -> next cycle level=0 and dbg_frame=0. With DEBUG_CAPTURE_TRIGGER_EN, trig_value=9'h0F0 and mask=9'h0F0, frames 9'h001, 9'h0F3, 9'h002 -> only 0F3 and 002 are stored, frame_cnt=2.
